// File: rtl/computation_controller.sv
// Sequencer for the serial, systolic and custom engines sharing one memory port.
// Steers the shared mux, enables engines, walks the four systolic feature passes and guards each phase with a watchdog.
module computation_controller #(
  parameter logic [5:0] FEAT_STRIDE = 6'd2,
  parameter logic [7:0] TIMEOUT     = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode_req,
  input  logic [7:0] serial_base_i,
  input  logic [5:0] systolic_base_i,
  input  logic       serial_mode_done,
  input  logic       weight_Preloader_done,
  input  logic       feature_Loader_done,
  input  logic       custom_mode_done,
  output logic       serial_mode_en,
  output logic       Weight_Preloader_en,
  output logic       Feature_Loader_en,
  output logic       custom_mode_en,
  output logic       systolic_mode,
  output logic [1:0] c_reg_sel,
  output logic [1:0] computation_mode_sel,
  output logic [7:0] serial_mode_feature_baseaddr,
  output logic [5:0] systolic_mode_feature_baseaddr,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE,
    SER_RUN,
    WL_RUN,
    FL_RUN,
    GAP,
    CUS_RUN,
    FIN
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] pass_q, pass_d;
  logic [7:0] wdog_q, wdog_d;
  logic [5:0] sys_base_q, sys_base_d;
  logic       ser_en_q, ser_en_d;
  logic       wl_en_q, wl_en_d;
  logic       fl_en_q, fl_en_d;
  logic       cus_en_q, cus_en_d;
  logic       sys_mode_q, sys_mode_d;
  logic [1:0] c_reg_q, c_reg_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] ser_addr_q, ser_addr_d;
  logic [5:0] sys_addr_q, sys_addr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;

  logic       accept;
  logic       timed_out;
  logic       in_run;

  // A phase times out on its TIMEOUT-th waiting cycle; a done flag sampled on that same edge still wins.
  assign timed_out = (wdog_q == (TIMEOUT - 8'd1));
  assign in_run    = (state_q == SER_RUN) || (state_q == WL_RUN) ||
                     (state_q == FL_RUN)  || (state_q == CUS_RUN);

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    sys_base_d = sys_base_q;
    sel_d      = sel_q;
    ser_addr_d = ser_addr_q;
    error_d    = 1'b0;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (mode_req == 2'b11) begin
            error_d = 1'b1;
          end else begin
            accept     = 1'b1;
            sel_d      = mode_req;
            ser_addr_d = serial_base_i;
            sys_base_d = systolic_base_i;
            pass_d     = 2'd0;
            case (mode_req)
              2'b00:   state_d = SER_RUN;
              2'b01:   state_d = WL_RUN;
              default: state_d = CUS_RUN;
            endcase
          end
        end
      end
      SER_RUN: begin
        if (serial_mode_done) begin
          state_d = FIN;
        end else if (timed_out) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      CUS_RUN: begin
        if (custom_mode_done) begin
          state_d = FIN;
        end else if (timed_out) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      WL_RUN: begin
        if (weight_Preloader_done) begin
          state_d = GAP;
          pass_d  = 2'd0;
        end else if (timed_out) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      GAP: begin
        state_d = FL_RUN;
      end
      FL_RUN: begin
        if (feature_Loader_done) begin
          if (pass_q == 2'd3) begin
            state_d = FIN;
          end else begin
            state_d = GAP;
            pass_d  = pass_q + 2'd1;
          end
        end else if (timed_out) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it with no extra latency.
  always_comb begin
    ser_en_d   = (state_d == SER_RUN);
    wl_en_d    = (state_d == WL_RUN);
    fl_en_d    = (state_d == FL_RUN);
    cus_en_d   = (state_d == CUS_RUN);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FIN);
    sys_mode_d = sys_mode_q;
    c_reg_d    = c_reg_q;
    sys_addr_d = sys_addr_q;
    wdog_d     = 8'd0;

    if (state_d == WL_RUN) begin
      sys_mode_d = 1'b0;
    end else if (state_d == FL_RUN) begin
      sys_mode_d = 1'b1;
    end

    if (accept) begin
      sys_addr_d = systolic_base_i;
    end else if (state_d == FL_RUN) begin
      c_reg_d    = pass_d;
      sys_addr_d = sys_base_d + ({4'b0000, pass_d} * FEAT_STRIDE);
    end

    if (in_run && (state_d == state_q)) begin
      wdog_d = wdog_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pass_q     <= 2'd0;
      wdog_q     <= 8'd0;
      sys_base_q <= 6'd0;
      ser_en_q   <= 1'b0;
      wl_en_q    <= 1'b0;
      fl_en_q    <= 1'b0;
      cus_en_q   <= 1'b0;
      sys_mode_q <= 1'b0;
      c_reg_q    <= 2'd0;
      sel_q      <= 2'b00;
      ser_addr_q <= 8'd0;
      sys_addr_q <= 6'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      wdog_q     <= wdog_d;
      sys_base_q <= sys_base_d;
      ser_en_q   <= ser_en_d;
      wl_en_q    <= wl_en_d;
      fl_en_q    <= fl_en_d;
      cus_en_q   <= cus_en_d;
      sys_mode_q <= sys_mode_d;
      c_reg_q    <= c_reg_d;
      sel_q      <= sel_d;
      ser_addr_q <= ser_addr_d;
      sys_addr_q <= sys_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign serial_mode_en                 = ser_en_q;
  assign Weight_Preloader_en            = wl_en_q;
  assign Feature_Loader_en              = fl_en_q;
  assign custom_mode_en                 = cus_en_q;
  assign systolic_mode                  = sys_mode_q;
  assign c_reg_sel                      = c_reg_q;
  assign computation_mode_sel           = sel_q;
  assign serial_mode_feature_baseaddr   = ser_addr_q;
  assign systolic_mode_feature_baseaddr = sys_addr_q;
  assign busy                           = busy_q;
  assign done                           = done_q;
  assign error                          = error_q;

endmodule

// File: doc/computation_controller.md
# computation_controller

Sequencing FSM that drives the computation module (serial, systolic and custom engines sharing one memory port). On a `start` request it selects the requested engine and steers the shared address/we/q muxes to it. It raises that engine's enable(s) and supplies base addresses and result-register selects. It waits on the engine's done flags, with a per-phase watchdog, and reports completion or timeout to the top-level FSM.

## Interface
- `FEAT_STRIDE`, 2: systolic feature base-address increment between consecutive feature-load passes (mod 64).
- `TIMEOUT`, 255: max cycles any single phase may wait for its done flag (8-bit counter; legal 1..255).
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse/level; sampled only in IDLE.
- `mode_req`  in  2  00 serial, 01 systolic, 10 custom, 11 illegal.
- `serial_base_i`  in  8  serial feature base address, latched at start.
- `systolic_base_i`  in  6  systolic feature base address, latched at start.
- `serial_mode_done`, `weight_Preloader_done`, `feature_Loader_done`, `custom_mode_done`  in  1 each  engine done flags (level, sampled).
- `serial_mode_en`, `Weight_Preloader_en`, `Feature_Loader_en`, `custom_mode_en`  out  1 each  engine enables (registered).
- `systolic_mode`  out  1  0 = weight preload, 1 = feature load.
- `c_reg_sel`  out  2  systolic result register: 0 c11, 1 c12, 2 c21, 3 c22.
- `computation_mode_sel`  out  2  shared-port mux select; same encoding as `mode_req`.
- `serial_mode_feature_baseaddr`  out  8;  `systolic_mode_feature_baseaddr`  out  6.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  one-cycle pulse: illegal mode or timeout.

## Operation
- States: IDLE, SER_RUN, WL_RUN, FL_RUN, GAP, CUS_RUN, FIN.
- IDLE: `start`=1 and `mode_req`≠11 → latch bases, `computation_mode_sel`←`mode_req`, go to SER_RUN / WL_RUN / CUS_RUN. `mode_req`=11 → `error` pulse next cycle, stay IDLE. `start` is ignored outside IDLE.
- SER_RUN: `serial_mode_en`=1, baseaddr = latched serial base. On `serial_mode_done` → FIN.
- CUS_RUN: `custom_mode_en`=1. On `custom_mode_done` → FIN.
- WL_RUN: `Weight_Preloader_en`=1, `systolic_mode`=0. On `weight_Preloader_done` → GAP, pass k=0.
- FL_RUN (pass k): `Feature_Loader_en`=1, `systolic_mode`=1, `c_reg_sel`=k, systolic baseaddr = base + k·FEAT_STRIDE (6-bit wrap). On `feature_Loader_done`: k<3 → GAP, k+1; k=3 → FIN.
- GAP: all enables 0 for exactly one cycle so engines rearm, then FL_RUN(k).
- FIN: `done`=1 for one cycle, enables 0, → IDLE.
- Watchdog: counter clears on entry to each *_RUN state and increments each cycle there. If the count reaches TIMEOUT with no done → all enables 0, `error` pulse, → IDLE (no `done`). A done flag arriving on the same cycle as the TIMEOUT hit wins (normal transition).
- Done flags are honoured only for the engine currently enabled. Others are ignored.
- `computation_mode_sel`, `c_reg_sel` and base-address outputs hold their last values in IDLE until the next accepted start.

## Timing
- Reset values: all enables 0, `systolic_mode` 0, `c_reg_sel` 0, `computation_mode_sel` 00, both baseaddr 0, `busy` 0, `done` 0, `error` 0, state IDLE, k 0, counter 0.
- `start` sampled at edge N → mux select, baseaddr and enable valid after edge N (1-cycle latency). Select and address change no later than the enable.
- Done sampled at edge M → enable low after edge M.
- Serial/custom: `done` high in cycle M+1.
- Systolic: WL done → one GAP cycle → FL enable. Each FL pass is followed by a GAP except the last. `done` is issued the cycle after the 4th FL done.
- Systolic total = WL + 4 FL durations + 4 GAP + 1 FIN cycles.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronously). After release, the block waits in IDLE for a fresh `start`.

## Test plan
- Reset, then `start`, `mode_req`=00, base 0x40, done after 10 cycles → `serial_mode_en` high 10 cycles, sel 00, baseaddr 0x40, `done` pulse 1 cycle after done, no `error`.
- `mode_req`=01, base 62, FEAT_STRIDE 2 → WL en with `systolic_mode` 0, then four FL passes with `c_reg_sel` 0,1,2,3 and baseaddr 62,0,2,4 (wrap), one zero-enable GAP before each pass, a single `done`.
- `mode_req`=10, custom done never asserted, TIMEOUT 255 → `custom_mode_en` drops after 255 cycles, `error` pulse, no `done`, `busy` 0.
- `mode_req`=11 → `error` pulse, no enable asserted, `computation_mode_sel` unchanged.
- During FL pass 2: spurious `serial_mode_done`, plus a second `start` with `mode_req`=00 → both ignored, sequence completes normally.
- `rst` asserted mid FL pass 1 → all outputs at reset values the same cycle. A later `start` with serial mode runs cleanly.
